// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared sizes and entry layout for the reservation station
package rs_pkg;

  localparam int RS_DEPTH  = 8;
  localparam int RS_DISP_W = 3;
  localparam int RS_WB_N   = 2;
  localparam int RS_PREG_W = 5;
  localparam int RS_ROB_W  = 4;
  localparam int RS_OP_W   = 4;
  localparam int IDX_W     = $clog2(RS_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [RS_OP_W-1:0]   op;
    logic [RS_PREG_W-1:0] pa;
    logic [RS_PREG_W-1:0] pb;
    logic [RS_PREG_W-1:0] pw;
    logic                 rdy_a;
    logic                 rdy_b;
    logic [RS_ROB_W-1:0]  tag;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - DEPTH x DEPTH age matrix with one-hot oldest-request grant
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] dealloc,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] gnt
);

  // older[r][c] = 1 when entry r is older than entry c
  logic [DEPTH-1:0] older [DEPTH];

  // Same-group allocations land on ascending indices in port order, so lower index is older.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) older[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          if (alloc[r])
            older[r][c] <= alloc[c] && (r < c);
          else if (alloc[c])
            older[r][c] <= 1'b1;
          else if (dealloc[r] || dealloc[c])
            older[r][c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (j != i && req[j] && older[j][i]) blocked = 1'b1;
      gnt[i] = req[i] && !blocked;
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation station: multi-port dispatch, tag wakeup, oldest-ready issue
// Optional RS_WAKE_BYPASS_EN lets select see same-cycle broadcast matches.
module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int DISP_W = RS_DISP_W,
  parameter int WB_N   = RS_WB_N,
  parameter int PREG_W = RS_PREG_W,
  parameter int ROB_W  = RS_ROB_W,
  parameter int OP_W   = RS_OP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     freeze_front,
  input  logic                     freeze_back,
  output logic                     full,
  input  logic [DISP_W-1:0]        disp_valid,
  input  logic [DISP_W*OP_W-1:0]   disp_op,
  input  logic [DISP_W*PREG_W-1:0] disp_pa,
  input  logic [DISP_W*PREG_W-1:0] disp_pb,
  input  logic [DISP_W*PREG_W-1:0] disp_pw,
  input  logic [DISP_W-1:0]        disp_rdy_a,
  input  logic [DISP_W-1:0]        disp_rdy_b,
  input  logic [DISP_W*ROB_W-1:0]  disp_tag,
  input  logic [WB_N-1:0]          wb_valid,
  input  logic [WB_N*PREG_W-1:0]   wb_pw,
  output logic                     iss_valid,
  output logic [OP_W-1:0]          iss_op,
  output logic [PREG_W-1:0]        iss_pa,
  output logic [PREG_W-1:0]        iss_pb,
  output logic [PREG_W-1:0]        iss_pw,
  output logic [ROB_W-1:0]         iss_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t        ent [DEPTH];
  logic [CNT_W-1:0] free_cnt, free_nx;
  logic [DEPTH-1:0] valid_q, rdy_a_q, rdy_b_q, wake_a, wake_b;
  logic [DEPTH-1:0] req, gnt, alloc, dealloc, valid_nx;
  logic [DISP_W-1:0] dwake_a, dwake_b;
  int               alloc_port [DEPTH];
  logic [IDX_W-1:0] sel_idx;
  logic             accept, do_issue;

  assign full     = free_cnt < CNT_W'(DISP_W);
  assign accept   = !full && !freeze_front && !flush;
  assign do_issue = !freeze_back && !flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_q[i] = ent[i].valid;
      rdy_a_q[i] = ent[i].rdy_a;
      rdy_b_q[i] = ent[i].rdy_b;
      wake_a[i]  = 1'b0;
      wake_b[i]  = 1'b0;
      for (int k = 0; k < WB_N; k++) begin
        if (wb_valid[k] && wb_pw[k*PREG_W +: PREG_W] == ent[i].pa) wake_a[i] = 1'b1;
        if (wb_valid[k] && wb_pw[k*PREG_W +: PREG_W] == ent[i].pb) wake_b[i] = 1'b1;
      end
    end
    for (int p = 0; p < DISP_W; p++) begin
      dwake_a[p] = 1'b0;
      dwake_b[p] = 1'b0;
      for (int k = 0; k < WB_N; k++) begin
        if (wb_valid[k] && wb_pw[k*PREG_W +: PREG_W] == disp_pa[p*PREG_W +: PREG_W]) dwake_a[p] = 1'b1;
        if (wb_valid[k] && wb_pw[k*PREG_W +: PREG_W] == disp_pb[p*PREG_W +: PREG_W]) dwake_b[p] = 1'b1;
      end
    end
  end

`ifdef RS_WAKE_BYPASS_EN
  assign req = valid_q & (rdy_a_q | wake_a) & (rdy_b_q | wake_b);
`else
  assign req = valid_q & rdy_a_q & rdy_b_q;
`endif

  assign dealloc = flush ? {DEPTH{1'b1}} : (do_issue ? gnt : '0);

  // Only registered-free slots are candidates, so a slot issued this cycle is reused next cycle.
  always_comb begin
    logic [DEPTH-1:0] avail;
    logic             found;
    alloc = '0;
    avail = ~valid_q;
    for (int i = 0; i < DEPTH; i++) alloc_port[i] = 0;
    for (int p = 0; p < DISP_W; p++) begin
      found = 1'b0;
      if (accept && disp_valid[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && avail[i]) begin
            alloc[i]      = 1'b1;
            alloc_port[i] = p;
            avail[i]      = 1'b0;
            found         = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    valid_nx = (valid_q & ~dealloc) | alloc;
    free_nx  = '0;
    sel_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_nx[i]) free_nx = free_nx + CNT_W'(1);
      if (gnt[i]) sel_idx = IDX_W'(i);
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .rst     (rst),
    .alloc   (alloc),
    .dealloc (dealloc),
    .req     (req),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      free_cnt  <= CNT_W'(DEPTH);
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_pa    <= '0;
      iss_pb    <= '0;
      iss_pw    <= '0;
      iss_tag   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc[i]) begin
          ent[i].valid <= 1'b1;
          ent[i].op    <= disp_op[alloc_port[i]*OP_W +: OP_W];
          ent[i].pa    <= disp_pa[alloc_port[i]*PREG_W +: PREG_W];
          ent[i].pb    <= disp_pb[alloc_port[i]*PREG_W +: PREG_W];
          ent[i].pw    <= disp_pw[alloc_port[i]*PREG_W +: PREG_W];
          ent[i].rdy_a <= disp_rdy_a[alloc_port[i]] | dwake_a[alloc_port[i]];
          ent[i].rdy_b <= disp_rdy_b[alloc_port[i]] | dwake_b[alloc_port[i]];
          ent[i].tag   <= disp_tag[alloc_port[i]*ROB_W +: ROB_W];
        end else begin
          if (dealloc[i]) ent[i].valid <= 1'b0;
          if (wake_a[i]) ent[i].rdy_a <= 1'b1;
          if (wake_b[i]) ent[i].rdy_b <= 1'b1;
        end
      end
      free_cnt <= free_nx;
      if (!freeze_back) begin
        iss_valid <= |gnt;
        if (|gnt) begin
          iss_op  <= ent[sel_idx].op;
          iss_pa  <= ent[sel_idx].pa;
          iss_pb  <= ent[sel_idx].pb;
          iss_pw  <= ent[sel_idx].pw;
          iss_tag <= ent[sel_idx].tag;
        end else begin
          iss_op  <= '0;
          iss_pa  <= '0;
          iss_pb  <= '0;
          iss_pw  <= '0;
          iss_tag <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed self-checking bench for rs_issue_queue
module tb_rs_issue_queue;

  localparam int DEPTH = 8, DISP_W = 3, WB_N = 2, PREG_W = 5, ROB_W = 4, OP_W = 4;

  logic                     clk = 1'b0;
  logic                     rst, flush, freeze_front, freeze_back, full;
  logic [DISP_W-1:0]        disp_valid, disp_rdy_a, disp_rdy_b;
  logic [DISP_W*OP_W-1:0]   disp_op;
  logic [DISP_W*PREG_W-1:0] disp_pa, disp_pb, disp_pw;
  logic [DISP_W*ROB_W-1:0]  disp_tag;
  logic [WB_N-1:0]          wb_valid;
  logic [WB_N*PREG_W-1:0]   wb_pw;
  logic                     iss_valid;
  logic [OP_W-1:0]          iss_op;
  logic [PREG_W-1:0]        iss_pa, iss_pb, iss_pw;
  logic [ROB_W-1:0]         iss_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rs_issue_queue #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .WB_N(WB_N),
    .PREG_W(PREG_W), .ROB_W(ROB_W), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_front(freeze_front),
    .freeze_back(freeze_back), .full(full),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_pa(disp_pa),
    .disp_pb(disp_pb), .disp_pw(disp_pw), .disp_rdy_a(disp_rdy_a),
    .disp_rdy_b(disp_rdy_b), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_pw(wb_pw),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_pa(iss_pa),
    .iss_pb(iss_pb), .iss_pw(iss_pw), .iss_tag(iss_tag)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_disp();
    disp_valid = '0; disp_op = '0; disp_pa = '0; disp_pb = '0;
    disp_pw = '0; disp_rdy_a = '0; disp_rdy_b = '0; disp_tag = '0;
  endtask

  task automatic put(input int p, input int op, input int pa, input int pb, input int pw,
                     input int ra, input int rb, input int tag);
    disp_valid[p] = 1'b1;
    disp_op[p*OP_W +: OP_W]       = OP_W'(op);
    disp_pa[p*PREG_W +: PREG_W]   = PREG_W'(pa);
    disp_pb[p*PREG_W +: PREG_W]   = PREG_W'(pb);
    disp_pw[p*PREG_W +: PREG_W]   = PREG_W'(pw);
    disp_rdy_a[p] = (ra != 0);
    disp_rdy_b[p] = (rb != 0);
    disp_tag[p*ROB_W +: ROB_W]    = ROB_W'(tag);
  endtask

  task automatic drain(input string name, input int t0, input int t1, input int t2, input int t3);
    int tags [4];
    tags = '{t0, t1, t2, t3};
    step();
    wb_valid = '0;
    wb_pw    = '0;
`ifndef RS_WAKE_BYPASS_EN
    check({name, "_gap"}, iss_valid, 0);
    step();
`endif
    for (int i = 0; i < 4; i++) begin
      check({name, "_iv"}, iss_valid, 1);
      check({name, "_tag"}, iss_tag, tags[i]);
      step();
    end
    check({name, "_end"}, iss_valid, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze_front = 1'b0; freeze_back = 1'b0;
    wb_valid = '0; wb_pw = '0;
    clear_disp();
    step();
    step();
    check("rst_iv", iss_valid, 0);
    check("rst_tag", iss_tag, 0);
    check("rst_op", iss_op, 0);
    check("rst_pw", iss_pw, 0);
    check("rst_full", full, 0);
    rst = 1'b0;

    // Three ready uops in one group: issue 1,2,3 starting two cycles later
    put(0, 3, 1, 2, 7, 1, 1, 1);
    put(1, 3, 1, 2, 8, 1, 1, 2);
    put(2, 3, 1, 2, 9, 1, 1, 3);
    step();
    clear_disp();
    check("lat_t1", iss_valid, 0);
    step();
    check("grp_iv0", iss_valid, 1);
    check("grp_tag0", iss_tag, 1);
    check("grp_op0", iss_op, 3);
    check("grp_pw0", iss_pw, 7);
    step();
    check("grp_tag1", iss_tag, 2);
    step();
    check("grp_tag2", iss_tag, 3);
    step();
    check("grp_end", iss_valid, 0);

    // Source A waits on preg 5, broadcast three cycles after dispatch
    put(0, 5, 5, 6, 10, 0, 1, 4);
    step();
    clear_disp();
    check("wk_t1", iss_valid, 0);
    step();
    check("wk_t2", iss_valid, 0);
    step();
    check("wk_t3", iss_valid, 0);
    wb_valid = 2'b01;
    wb_pw[0 +: PREG_W] = 5'd5;
    step();
    wb_valid = '0;
    wb_pw = '0;
`ifdef RS_WAKE_BYPASS_EN
    check("wk_iv", iss_valid, 1);
    check("wk_tag", iss_tag, 4);
    check("wk_pa", iss_pa, 5);
    step();
    check("wk_end", iss_valid, 0);
`else
    check("wk_gap", iss_valid, 0);
    step();
    check("wk_iv", iss_valid, 1);
    check("wk_tag", iss_tag, 4);
    check("wk_pa", iss_pa, 5);
    step();
    check("wk_end", iss_valid, 0);
`endif

    // Fill all 8 entries unready in groups of 3, 2, 3
    put(0, 1, 10, 0, 1, 0, 1, 1);
    put(1, 1, 11, 0, 2, 0, 1, 2);
    put(2, 1, 10, 0, 3, 0, 1, 3);
    step();
    clear_disp();
    check("fill3_full", full, 0);
    put(0, 1, 12, 0, 4, 0, 1, 4);
    put(1, 1, 10, 0, 5, 0, 1, 5);
    step();
    clear_disp();
    check("fill5_full", full, 0);
    put(0, 1, 11, 0, 6, 0, 1, 6);
    put(1, 1, 12, 0, 7, 0, 1, 7);
    put(2, 1, 10, 0, 8, 0, 1, 8);
    step();
    clear_disp();
    check("fill8_full", full, 1);
    check("fill8_iv", iss_valid, 0);
    put(0, 2, 0, 0, 0, 1, 1, 9);
    step();
    clear_disp();
    check("rej_full", full, 1);
    check("rej_iv0", iss_valid, 0);
    step();
    check("rej_iv1", iss_valid, 0);

    wb_valid = 2'b10;
    wb_pw[PREG_W +: PREG_W] = 5'd10;
    drain("wk10", 1, 3, 5, 8);
    check("wk10_full", full, 0);

    wb_valid = 2'b11;
    wb_pw[0 +: PREG_W]      = 5'd11;
    wb_pw[PREG_W +: PREG_W] = 5'd12;
    drain("wk1112", 2, 4, 6, 7);
    check("empty_full", full, 0);

    // freeze_back holds the issue register; dispatch continues meanwhile
    put(0, 6, 1, 2, 11, 1, 1, 10);
    put(1, 7, 1, 2, 12, 1, 1, 11);
    step();
    clear_disp();
    step();
    check("frz_pre", iss_tag, 10);
    freeze_back = 1'b1;
    step();
    check("frz1_iv", iss_valid, 1);
    check("frz1_tag", iss_tag, 10);
    put(0, 8, 1, 2, 13, 1, 1, 12);
    step();
    clear_disp();
    check("frz2_tag", iss_tag, 10);
    check("frz2_pw", iss_pw, 11);
    step();
    check("frz3_tag", iss_tag, 10);
    freeze_back = 1'b0;
    step();
    check("frz_res0", iss_tag, 11);
    step();
    check("frz_res1", iss_tag, 12);
    step();
    check("frz_end", iss_valid, 0);

    // flush beats dispatch, wakeup and issue in the same cycle
    put(0, 8, 1, 2, 13, 1, 1, 14);
    put(1, 9, 20, 2, 14, 0, 1, 13);
    step();
    clear_disp();
    step();
    check("fl_pre", iss_tag, 14);
    flush = 1'b1;
    put(0, 1, 1, 2, 3, 1, 1, 1);
    put(1, 1, 1, 2, 4, 1, 1, 2);
    wb_valid = 2'b01;
    wb_pw[0 +: PREG_W] = 5'd20;
    step();
    flush = 1'b0;
    clear_disp();
    wb_valid = '0;
    wb_pw = '0;
    check("fl_iv", iss_valid, 0);
    check("fl_tag", iss_tag, 0);
    check("fl_pw", iss_pw, 0);
    check("fl_full", full, 0);
    step();
    check("fl_iv1", iss_valid, 0);
    step();
    check("fl_iv2", iss_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
